// File: rtl/jtag_tap_core.sv
// JTAG TAP core: IEEE 1149.1 TAP controller, instruction register, BYPASS/IDCODE
// data registers and a multi-channel user data-register port.
//
// state  | meaning
// -------+-----------------------------------------------
// TLR    | Test-Logic-Reset, IR forced to IDCODE
// IDLE   | Run-Test/Idle
// SELDR  | Select-DR-Scan
// CAPDR  | Capture-DR, selected DR loads its capture value
// SHDR   | Shift-DR, selected DR shifts tdi -> tdo
// EX1DR  | Exit1-DR
// PDR    | Pause-DR
// EX2DR  | Exit2-DR
// UPDR   | Update-DR
// SELIR  | Select-IR-Scan
// CAPIR  | Capture-IR, ir_shift loads 0..01
// SHIR   | Shift-IR
// EX1IR  | Exit1-IR
// PIR    | Pause-IR
// EX2IR  | Exit2-IR
// UPIR   | Update-IR, ir_q loads ir_shift on exit
module jtag_tap_core #(
   parameter int          IR_W      = 4,
   parameter logic [31:0] IDCODE    = 32'h1000_0001,
   parameter int          NUM_USER  = 2,
   parameter int          USER_BASE = 8
) (
   input  logic                clk,
   input  logic                tap_por,
   input  logic                enableIn,
   input  logic                tms,
   input  logic                tdi,
   output logic                tdo,
   output logic                tdo_oe,
   output logic [3:0]          tstate,
   output logic [IR_W-1:0]     ir_q,
   output logic                reset_n,
   output logic [NUM_USER-1:0] user_sel,
   output logic                user_capture,
   output logic                user_shift,
   output logic                user_update,
   output logic                user_tdi,
   input  logic [NUM_USER-1:0] user_tdo
);

   typedef enum logic [3:0] {
      S_TLR   = 4'd0,
      S_IDLE  = 4'd1,
      S_SELDR = 4'd2,
      S_CAPDR = 4'd3,
      S_SHDR  = 4'd4,
      S_EX1DR = 4'd5,
      S_PDR   = 4'd6,
      S_EX2DR = 4'd7,
      S_UPDR  = 4'd8,
      S_SELIR = 4'd9,
      S_CAPIR = 4'd10,
      S_SHIR  = 4'd11,
      S_EX1IR = 4'd12,
      S_PIR   = 4'd13,
      S_EX2IR = 4'd14,
      S_UPIR  = 4'd15
   } tap_state_t;

   localparam logic [IR_W-1:0] C_IR_IDCODE = {{(IR_W-1){1'b0}}, 1'b1};

   tap_state_t          r_state;
   tap_state_t          w_state_nxt;
   logic [IR_W-1:0]     r_ir_shift;
   logic [IR_W-1:0]     r_ir_q;
   logic                r_bypass;
   logic [31:0]         r_idcode_sr;
   logic                r_tdo;
   logic                r_tdo_oe;

   logic [NUM_USER-1:0] w_user_sel;
   logic                w_is_idcode;
   logic                w_is_user;
   logic                w_dr_out;

   // ---------------------------------------------------------------
   // TAP state register and next-state logic
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge tap_por) begin
      if (!tap_por) begin
         r_state <= S_TLR;
      end else if (enableIn) begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_TLR:   w_state_nxt = tms ? S_TLR   : S_IDLE;
         S_IDLE:  w_state_nxt = tms ? S_SELDR : S_IDLE;
         S_SELDR: w_state_nxt = tms ? S_SELIR : S_CAPDR;
         S_CAPDR: w_state_nxt = tms ? S_EX1DR : S_SHDR;
         S_SHDR:  w_state_nxt = tms ? S_EX1DR : S_SHDR;
         S_EX1DR: w_state_nxt = tms ? S_UPDR  : S_PDR;
         S_PDR:   w_state_nxt = tms ? S_EX2DR : S_PDR;
         S_EX2DR: w_state_nxt = tms ? S_UPDR  : S_SHDR;
         S_UPDR:  w_state_nxt = tms ? S_SELDR : S_IDLE;
         S_SELIR: w_state_nxt = tms ? S_TLR   : S_CAPIR;
         S_CAPIR: w_state_nxt = tms ? S_EX1IR : S_SHIR;
         S_SHIR:  w_state_nxt = tms ? S_EX1IR : S_SHIR;
         S_EX1IR: w_state_nxt = tms ? S_UPIR  : S_PIR;
         S_PIR:   w_state_nxt = tms ? S_EX2IR : S_PIR;
         S_EX2IR: w_state_nxt = tms ? S_UPIR  : S_SHIR;
         S_UPIR:  w_state_nxt = tms ? S_SELDR : S_IDLE;
         default: w_state_nxt = S_TLR;
      endcase
   end

   // ---------------------------------------------------------------
   // Instruction register: capture/shift in ir_shift, commit on UpIR exit
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge tap_por) begin
      if (!tap_por) begin
         r_ir_shift <= '0;
         r_ir_q     <= C_IR_IDCODE;
      end else if (enableIn) begin
         case (r_state)
            S_TLR:   r_ir_q     <= C_IR_IDCODE;
            S_CAPIR: r_ir_shift <= C_IR_IDCODE;
            S_SHIR:  r_ir_shift <= {tdi, r_ir_shift[IR_W-1:1]};
            S_UPIR:  r_ir_q     <= r_ir_shift;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Instruction decode; anything not IDCODE or a user opcode is BYPASS
   // ---------------------------------------------------------------
   for (genvar g = 0; g < NUM_USER; g++) begin : g_user_dec
      localparam int unsigned      C_OP_I = USER_BASE + g;
      localparam logic [IR_W-1:0]  C_OP   = C_OP_I[IR_W-1:0];
      assign w_user_sel[g] = (r_ir_q == C_OP);
   end

   assign w_is_idcode = (r_ir_q == C_IR_IDCODE);
   assign w_is_user   = |w_user_sel;

   // ---------------------------------------------------------------
   // Internal data registers; user chains keep their own shift state
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge tap_por) begin
      if (!tap_por) begin
         r_bypass    <= 1'b0;
         r_idcode_sr <= IDCODE;
      end else if (enableIn) begin
         if (w_is_idcode) begin
            if (r_state == S_CAPDR) begin
               r_idcode_sr <= IDCODE;
            end else if (r_state == S_SHDR) begin
               r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
            end
         end else if (!w_is_user) begin
            if (r_state == S_CAPDR) begin
               r_bypass <= 1'b0;
            end else if (r_state == S_SHDR) begin
               r_bypass <= tdi;
            end
         end
      end
   end

   always_comb begin
      w_dr_out = r_bypass;
      if (w_is_idcode) begin
         w_dr_out = r_idcode_sr[0];
      end else if (w_is_user) begin
         w_dr_out = |(w_user_sel & user_tdo);
      end
   end

   // ---------------------------------------------------------------
   // TDO launches on the falling edge so it is stable at the next rising edge
   // ---------------------------------------------------------------
   always_ff @(negedge clk or negedge tap_por) begin
      if (!tap_por) begin
         r_tdo    <= 1'b0;
         r_tdo_oe <= 1'b0;
      end else if (enableIn) begin
         case (r_state)
            S_SHIR: begin
               r_tdo    <= r_ir_shift[0];
               r_tdo_oe <= 1'b1;
            end
            S_SHDR: begin
               r_tdo    <= w_dr_out;
               r_tdo_oe <= 1'b1;
            end
            default: begin
               r_tdo    <= 1'b0;
               r_tdo_oe <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign tdo          = r_tdo;
   assign tdo_oe       = r_tdo_oe;
   assign tstate       = r_state;
   assign ir_q         = r_ir_q;
   assign reset_n      = (r_state != S_TLR);
   assign user_sel     = w_user_sel;
   assign user_capture = (r_state == S_CAPDR) && w_is_user;
   assign user_shift   = (r_state == S_SHDR)  && w_is_user;
   assign user_update  = (r_state == S_UPDR)  && w_is_user;
   assign user_tdi     = tdi;

endmodule
